// File: rtl/key_int_arbiter.sv
// Key-press interrupt arbiter: edge-detects per-channel key levels, queues one event per
// channel and serves them in fixed priority as bounded interrupt pulses separated by a gap.
module key_int_arbiter #(
  parameter int N_CH      = 4,
  parameter int PULSE_LEN = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         press,
  input  logic [N_CH-1:0]         mask,
  input  logic                    int_ack,
  output logic                    interrupt,
  output logic [$clog2(N_CH)-1:0] int_id,
  output logic [N_CH-1:0]         pending
);

  localparam int ID_W  = $clog2(N_CH);
  localparam int CNT_W = $clog2(PULSE_LEN + 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ID_W-1:0]  sel, id_nxt;
  logic [N_CH-1:0]  press_q, rise_set, eligible, clr, pending_nxt;

  assign rise_set = press & ~press_q & ~mask;
  assign eligible = pending & ~mask;

  // Scan downwards so the lowest eligible index wins.
  always_comb begin
    sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (eligible[i]) sel = ID_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    id_nxt    = int_id;
    clr       = '0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_nxt = PULSE;
          cnt_nxt   = CNT_W'(PULSE_LEN);
          id_nxt    = sel;
          clr[sel]  = 1'b1;
        end
      end
      PULSE: begin
        if (int_ack || cnt == CNT_W'(1)) state_nxt = GAP;
        else                             cnt_nxt   = cnt - CNT_W'(1);
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A new rise on the channel being cleared keeps its pending bit.
    pending_nxt = (pending & ~clr) | rise_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Reset press_q to ones so keys held through reset need a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      interrupt <= 1'b0;
      int_id    <= '0;
      pending   <= '0;
      cnt       <= '0;
      press_q   <= '1;
    end else begin
      interrupt <= (state_nxt == PULSE);
      int_id    <= id_nxt;
      pending   <= pending_nxt;
      cnt       <= cnt_nxt;
      press_q   <= press;
    end
  end

endmodule

// File: tb/tb_key_int_arbiter.sv
// Directed self-checking bench for key_int_arbiter (PULSE_LEN=6 and PULSE_LEN=1 instances).
module tb_key_int_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] press, press1, mask;
  logic       int_ack;
  logic       interrupt, interrupt1;
  logic [1:0] int_id, int_id1;
  logic [3:0] pending, pending1;

  int checks = 0;
  int errors = 0;

  key_int_arbiter #(.N_CH(4), .PULSE_LEN(6)) dut (
    .clk(clk), .rst_n(rst_n), .press(press), .mask(mask), .int_ack(int_ack),
    .interrupt(interrupt), .int_id(int_id), .pending(pending)
  );

  key_int_arbiter #(.N_CH(4), .PULSE_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .press(press1), .mask(mask), .int_ack(int_ack),
    .interrupt(interrupt1), .int_id(int_id1), .pending(pending1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_int: got %b want 0", interrupt); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rst_pending: got %b want 0000", pending); end
    checks++; if (int_id !== 2'd0) begin errors++; $display("FAIL rst_id: got %0d want 0", int_id); end
    checks++; if (interrupt1 !== 1'b0) begin errors++; $display("FAIL rst_int1: got %b want 0", interrupt1); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    checks++; if (interrupt !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL rst_release: got int=%b pend=%b want 0/0000", interrupt, pending); end
  endtask

  task automatic test_single_press();
    for (int r = 0; r < 2; r++) begin
      press = 4'b0100;
      step();
      checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL sp_pending_e0[%0d]: got %b want 0100", r, pending); end
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL sp_int_e0[%0d]: got %b want 0", r, interrupt); end
      step();
      checks++; if (interrupt !== 1'b1 || int_id !== 2'd2) begin errors++; $display("FAIL sp_start[%0d]: got int=%b id=%0d want 1/2", r, interrupt, int_id); end
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL sp_pending_e1[%0d]: got %b want 0000", r, pending); end
      for (int k = 0; k < 17; k++) begin
        step();
        checks++; if (interrupt !== (k < 5)) begin errors++; $display("FAIL sp_cycle[%0d][%0d]: got %b want %b", r, k, interrupt, (k < 5)); end
      end
      press = 4'b0000;
      step();
      step();
    end
  endtask

  task automatic test_simultaneous();
    press = 4'b1010;
    step();
    checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL sim_pending: got %b want 1010", pending); end
    step();
    checks++; if (interrupt !== 1'b1 || int_id !== 2'd1 || pending !== 4'b1000) begin errors++; $display("FAIL sim_first: got int=%b id=%0d pend=%b want 1/1/1000", interrupt, int_id, pending); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (interrupt !== 1'b1 || int_id !== 2'd1) begin errors++; $display("FAIL sim_first_hold[%0d]: got int=%b id=%0d want 1/1", k, interrupt, int_id); end
    end
    step();
    checks++; if (interrupt !== 1'b0 || int_id !== 2'd1) begin errors++; $display("FAIL sim_gap: got int=%b id=%0d want 0/1", interrupt, int_id); end
    step();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL sim_idle: got %b want 0", interrupt); end
    step();
    checks++; if (interrupt !== 1'b1 || int_id !== 2'd3 || pending !== 4'b0000) begin errors++; $display("FAIL sim_second: got int=%b id=%0d pend=%b want 1/3/0000", interrupt, int_id, pending); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL sim_second_hold[%0d]: got %b want 1", k, interrupt); end
    end
    step();
    checks++; if (interrupt !== 1'b0 || int_id !== 2'd3) begin errors++; $display("FAIL sim_end: got int=%b id=%0d want 0/3", interrupt, int_id); end
    step();
    press = 4'b0000;
    step();
  endtask

  task automatic test_early_ack();
    press = 4'b0001;
    step();
    step();
    checks++; if (interrupt !== 1'b1 || int_id !== 2'd0) begin errors++; $display("FAIL ack_start: got int=%b id=%0d want 1/0", interrupt, int_id); end
    step();
    step();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL ack_third: got %b want 1", interrupt); end
    int_ack = 1'b1;
    step();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ack_drop: got %b want 0", interrupt); end
    int_ack = 1'b0;
    step();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ack_gap: got %b want 0", interrupt); end
    step();
    checks++; if (interrupt !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL ack_idle: got int=%b pend=%b want 0/0000", interrupt, pending); end
    press = 4'b0000;
    step();
  endtask

  task automatic test_masking();
    mask  = 4'b0001;
    press = 4'b0001;
    step();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL mask_drop: got %b want 0000", pending); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL mask_nopulse[%0d]: got %b want 0", k, interrupt); end
    end
    press = 4'b0011;
    step();
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL mask_set1: got %b want 0010", pending); end
    mask = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (interrupt !== 1'b0 || pending !== 4'b0010) begin errors++; $display("FAIL mask_hold[%0d]: got int=%b pend=%b want 0/0010", k, interrupt, pending); end
    end
    mask = 4'b0001;
    step();
    checks++; if (interrupt !== 1'b1 || int_id !== 2'd1 || pending !== 4'b0000) begin errors++; $display("FAIL mask_release: got int=%b id=%0d pend=%b want 1/1/0000", interrupt, int_id, pending); end
    repeat (7) step();
    mask  = 4'b0000;
    press = 4'b0000;
    step();
  endtask

  task automatic test_repress();
    press = 4'b0100;
    step();
    step();
    checks++; if (interrupt !== 1'b1 || int_id !== 2'd2) begin errors++; $display("FAIL rp_start: got int=%b id=%0d want 1/2", interrupt, int_id); end
    press = 4'b0000;
    step();
    press = 4'b0100;
    step();
    checks++; if (pending !== 4'b0100 || interrupt !== 1'b1) begin errors++; $display("FAIL rp_queued: got int=%b pend=%b want 1/0100", interrupt, pending); end
    repeat (3) step();
    step();
    checks++; if (interrupt !== 1'b0 || int_id !== 2'd2) begin errors++; $display("FAIL rp_gap: got int=%b id=%0d want 0/2", interrupt, int_id); end
    press = 4'b0000;
    step();
    press = 4'b0100;
    step();
    checks++; if (interrupt !== 1'b1 || int_id !== 2'd2 || pending !== 4'b0100) begin errors++; $display("FAIL rp_set_wins: got int=%b id=%0d pend=%b want 1/2/0100", interrupt, int_id, pending); end
    repeat (8) step();
    checks++; if (interrupt !== 1'b1 || int_id !== 2'd2 || pending !== 4'b0000) begin errors++; $display("FAIL rp_third: got int=%b id=%0d pend=%b want 1/2/0000", interrupt, int_id, pending); end
    repeat (7) step();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rp_end: got %b want 0", interrupt); end
    press = 4'b0000;
    step();
  endtask

  task automatic test_pulse_len1();
    press1 = 4'b0100;
    step();
    checks++; if (pending1 !== 4'b0100) begin errors++; $display("FAIL p1_pending: got %b want 0100", pending1); end
    step();
    checks++; if (interrupt1 !== 1'b1 || int_id1 !== 2'd2) begin errors++; $display("FAIL p1_start: got int=%b id=%0d want 1/2", interrupt1, int_id1); end
    press1 = 4'b0000;
    step();
    checks++; if (interrupt1 !== 1'b0) begin errors++; $display("FAIL p1_single: got %b want 0", interrupt1); end
    press1 = 4'b0100;
    step();
    checks++; if (interrupt1 !== 1'b0 || pending1 !== 4'b0100) begin errors++; $display("FAIL p1_idle: got int=%b pend=%b want 0/0100", interrupt1, pending1); end
    step();
    checks++; if (interrupt1 !== 1'b1 || int_id1 !== 2'd2 || pending1 !== 4'b0000) begin errors++; $display("FAIL p1_second: got int=%b id=%0d pend=%b want 1/2/0000", interrupt1, int_id1, pending1); end
    step();
    checks++; if (interrupt1 !== 1'b0) begin errors++; $display("FAIL p1_second_end: got %b want 0", interrupt1); end
    press1 = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_pulse();
    press = 4'b1000;
    step();
    step();
    checks++; if (interrupt !== 1'b1 || int_id !== 2'd3) begin errors++; $display("FAIL rm_start: got int=%b id=%0d want 1/3", interrupt, int_id); end
    press = 4'b1010;
    step();
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL rm_queued: got %b want 0010", pending); end
    #3;
    rst_n = 1'b0;
    press = 4'b0001;
    #1;
    checks++; if (interrupt !== 1'b0 || pending !== 4'b0000 || int_id !== 2'd0) begin errors++; $display("FAIL rm_async: got int=%b pend=%b id=%0d want 0/0000/0", interrupt, pending, int_id); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (interrupt !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL rm_held[%0d]: got int=%b pend=%b want 0/0000", k, interrupt, pending); end
    end
    press = 4'b0000;
    step();
    press = 4'b0001;
    step();
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL rm_repress: got %b want 0001", pending); end
    step();
    checks++; if (interrupt !== 1'b1 || int_id !== 2'd0) begin errors++; $display("FAIL rm_pulse: got int=%b id=%0d want 1/0", interrupt, int_id); end
    repeat (7) step();
    press = 4'b0000;
    step();
  endtask

  initial begin
    rst_n   = 1'b1;
    press   = '0;
    press1  = '0;
    mask    = '0;
    int_ack = 1'b0;
    test_reset();
    test_single_press();
    test_simultaneous();
    test_early_ack();
    test_masking();
    test_repress();
    test_pulse_len1();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_int_arbiter.md
KEY_INT_ARBITER -- requirements
Module: key_int_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of key/press channels (legal range 2..16).
REQ-002 The block SHALL have parameter PULSE_LEN, default 6, meaning the maximum interrupt pulse length in clk cycles (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit, the single rising-edge clock for all state.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port press, input, N_CH bits, the per-channel key-held levels, already synchronous to clk.
REQ-006 The block SHALL have port mask, input, N_CH bits, where 1 means the channel is disabled.
REQ-007 The block SHALL have port int_ack, input, 1 bit, the CPU acknowledge that ends the current pulse early.
REQ-008 The block SHALL have port interrupt, output, 1 bit, the interrupt request to the CPU.
REQ-009 The block SHALL have port int_id, output, $clog2(N_CH) bits, the channel being served, valid while interrupt=1.
REQ-010 The block SHALL have port pending, output, N_CH bits, the channels waiting for service.

Function
REQ-011 Each channel SHALL register press into press_q; a rise on channel i is defined as press[i]=1 and press_q[i]=0.
REQ-012 A rise on an unmasked channel SHALL set pending[i] at that clock edge.
REQ-013 A rise on a masked channel SHALL be dropped.
REQ-014 A held key SHALL produce exactly one rise, so a channel re-arms only after press[i] is sampled 0 for at least one cycle.
REQ-015 If mask[i] is set after pending[i]=1, pending[i] SHALL be retained but the channel SHALL NOT be eligible for service until mask[i]=0.
REQ-016 The FSM SHALL have three states: IDLE, PULSE and GAP.
REQ-017 In IDLE, if any bit of (pending & ~mask) is set, the FSM SHALL go to PULSE, select the lowest eligible index i (fixed priority), latch int_id=i, clear pending[i] and load the counter with PULSE_LEN.
REQ-018 interrupt SHALL be 1 exactly when the state is PULSE, as a registered Moore output.
REQ-019 In PULSE, the counter SHALL decrement each cycle, and the FSM SHALL go to GAP when the counter reaches 1 or when int_ack=1, whichever occurs first.
REQ-020 int_ack SHALL be ignored outside PULSE.
REQ-021 GAP SHALL last exactly 1 cycle with interrupt=0, then the FSM SHALL go to IDLE.
REQ-022 The minimum spacing between two pulses SHALL be 2 low cycles: GAP plus the IDLE decision.
REQ-023 Latency: if a rise is sampled at edge E0, pending SHALL be set after E0, interrupt SHALL go high after E1, and with no ack interrupt SHALL go low after E1+PULSE_LEN.
REQ-024 int_id SHALL hold its value through PULSE and GAP, and SHALL change only on IDLE->PULSE.
REQ-025 If a rise occurs on the same channel in the cycle its pending bit is cleared, the set SHALL take priority over the clear and pending[i] SHALL stay 1.
REQ-026 Rises on multiple channels in the same cycle SHALL all set their pending bits, and they SHALL be served in ascending index order, one pulse each.
REQ-027 Rises during PULSE or GAP SHALL be queued in pending and SHALL NOT be lost.
REQ-028 Each channel SHALL queue at most one pending event; repeated rises while pending SHALL merge.
REQ-029 The counter width SHALL be $clog2(PULSE_LEN+1) bits, with no wrap-around, because the counter never decrements below 1 in PULSE.

Reset
REQ-030 While rst_n=0, regardless of clk, the outputs SHALL be: state=IDLE, interrupt=0, int_id=0, pending=0, counter=0.
REQ-031 While rst_n=0, press_q SHALL be set to all ones, so a key held through reset release produces no interrupt until it is released and pressed again.
REQ-032 Asserting rst_n mid-PULSE SHALL drop interrupt immediately and discard all pending events.
REQ-033 The first state transition SHALL occur on the first clk rising edge after rst_n is sampled high.

Verification
REQ-034 Single press: N_CH=4, PULSE_LEN=6, press[2] 0->1 held 20 cycles -> interrupt high for exactly 6 cycles starting 2 cycles after the rise, int_id=2, one pulse only; release then press again -> a second identical pulse.
REQ-035 Simultaneous press: press=4'b1010 rising in one cycle -> pending=1010, then pulse with int_id=1 (6 cycles), 1 low GAP cycle plus 1 IDLE cycle, then pulse with int_id=3, after which pending=0.
REQ-036 Early ack: int_ack=1 in the 3rd pulse cycle -> interrupt low on the next cycle (pulse 3 cycles long), then GAP, then IDLE.
REQ-037 Masking: mask[0]=1 with press[0] rising -> no pending bit and no pulse; with pending[1]=1, setting mask[1]=1 holds pending[1]=1 with no pulse; clearing mask[1] -> pulse with int_id=1.
REQ-038 Reset: rst_n=0 mid-pulse -> interrupt=0 and pending=0 without any clk edge; release rst_n with press[0] held -> no interrupt until press[0] goes 0 then 1.
REQ-039 Re-press during service: press[2] released and re-pressed during its own PULSE -> pending[2]=1 and a second pulse for channel 2 after GAP; repeat with PULSE_LEN=1 to check the single-cycle pulse boundary.
